mem_port_arbiter: RTL and testbench

- Owns the single memory bus port and shares it between three requesters: instruction fetch, MEM-stage loads and MEM-stage stores.
- Sequences each granted transaction through address, write-data and response phases.
- Returns load data as a 64-bit load buffer, and fetch data as a stream of beats.
- Produces the load_done, store_opn and completion signals that the MEM stage uses to release stalled instructions.

---
 rtl/mem_port_arbiter_if.sv | 52 +++++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the memory port arbiter, its three requesters and the bus.
// master: arbiter side; slave: requesters/bus side (testbench, bus model).
// Backpressure: bus_reqack on requests, bus_respack on responses.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_beat_valid;
    logic [63:0] if_beat_data;
    logic        if_done;

    logic        data_reqFlag;
    logic [63:0] data_reqAddr;
    logic        load_done;
    logic [63:0] load_buffer;

    logic        store_reqFlag;
    logic [63:0] store_reqAddr;
    logic [63:0] store_data;
    logic        store_opn;
    logic        store_done;

    logic        bus_reqcyc;
    logic        bus_reqack;
    logic [63:0] bus_req;
    logic [1:0]  bus_reqtag;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [1:0]  bus_resptag;
    logic        bus_respack;

    modport master (
        input  if_req, if_addr,
        input  data_reqFlag, data_reqAddr,
        input  store_reqFlag, store_reqAddr, store_data,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output if_beat_valid, if_beat_data, if_done,
        output load_done, load_buffer,
        output store_opn, store_done,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport slave (
        output if_req, if_addr,
        output data_reqFlag, data_reqAddr,
        output store_reqFlag, store_reqAddr, store_data,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  if_beat_valid, if_beat_data, if_done,
        input  load_done, load_buffer,
        input  store_opn, store_done,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between fetch, load and store; one transaction outstanding.
// Latency: request beat 1 cycle after grant; done pulses 1 cycle after the final handshake.
// Backpressure: holds request beats until bus_reqack; acks every response beat immediately.
module mem_port_arbiter #(
    parameter int IF_BEATS     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_port_arbiter_if.master mp
);
    localparam int CNT_W   = (IF_BEATS > 1) ? $clog2(IF_BEATS) : 1;
    localparam int STV_W   = $clog2(STARVE_LIMIT + 1);
    localparam int LINE_LSB = $clog2(IF_BEATS * 8);
    localparam logic [63:0] LINE_MASK = ~((64'd1 << LINE_LSB) - 64'd1);
    localparam logic [63:0] DW_MASK   = ~64'd7;
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(IF_BEATS - 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    localparam logic [1:0] TAG_FETCH = 2'b00;
    localparam logic [1:0] TAG_LOAD  = 2'b01;
    localparam logic [1:0] TAG_STORE = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RESP} state_t;

    state_t            state;
    logic [1:0]        tag_q;
    logic [63:0]       wdata_q;
    logic [CNT_W-1:0]  beat_cnt;
    logic [STV_W-1:0]  fetch_starve;

    logic              bus_reqcyc_q;
    logic [63:0]       bus_req_q;
    logic [1:0]        bus_reqtag_q;
    logic              store_opn_q;
    logic              store_done_q;
    logic              load_done_q;
    logic              if_done_q;
    logic [63:0]       load_buffer_q;

    // A requester whose done pulse is high is still holding its level request; mask it.
    logic fe_cand, ld_cand, st_cand;
    assign fe_cand = mp.if_req        & ~if_done_q;
    assign ld_cand = mp.data_reqFlag  & ~load_done_q;
    assign st_cand = mp.store_reqFlag & ~store_done_q;

    logic        grant_vld;
    logic [1:0]  grant_tag;
    logic [63:0] grant_addr;

    always_comb begin
        grant_vld  = 1'b0;
        grant_tag  = TAG_FETCH;
        grant_addr = '0;
        if (fe_cand && fetch_starve == STARVE_MAX) begin
            grant_vld  = 1'b1;
            grant_tag  = TAG_FETCH;
            grant_addr = mp.if_addr & LINE_MASK;
        end else if (st_cand) begin
            grant_vld  = 1'b1;
            grant_tag  = TAG_STORE;
            grant_addr = mp.store_reqAddr & DW_MASK;
        end else if (ld_cand) begin
            grant_vld  = 1'b1;
            grant_tag  = TAG_LOAD;
            grant_addr = mp.data_reqAddr & DW_MASK;
        end else if (fe_cand) begin
            grant_vld  = 1'b1;
            grant_tag  = TAG_FETCH;
            grant_addr = mp.if_addr & LINE_MASK;
        end
    end

    logic resp_match;
    assign resp_match = (state == RESP) && mp.bus_respcyc && (mp.bus_resptag == tag_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            tag_q         <= '0;
            wdata_q       <= '0;
            beat_cnt      <= '0;
            fetch_starve  <= '0;
            bus_reqcyc_q  <= 1'b0;
            bus_req_q     <= '0;
            bus_reqtag_q  <= '0;
            store_opn_q   <= 1'b0;
            store_done_q  <= 1'b0;
            load_done_q   <= 1'b0;
            if_done_q     <= 1'b0;
            load_buffer_q <= '0;
        end else begin
            store_done_q <= 1'b0;
            load_done_q  <= 1'b0;
            if_done_q    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state        <= REQ;
                        tag_q        <= grant_tag;
                        bus_reqcyc_q <= 1'b1;
                        bus_req_q    <= grant_addr;
                        bus_reqtag_q <= grant_tag;
                        store_opn_q  <= (grant_tag == TAG_STORE);
                        if (grant_tag == TAG_STORE)
                            wdata_q <= mp.store_data;
                        if (grant_tag == TAG_FETCH)
                            fetch_starve <= '0;
                        else if (mp.if_req && fetch_starve != STARVE_MAX)
                            fetch_starve <= fetch_starve + 1'b1;
                    end
                end
                REQ: begin
                    if (mp.bus_reqack) begin
                        if (tag_q == TAG_STORE) begin
                            state     <= WDATA;
                            bus_req_q <= wdata_q;
                        end else begin
                            state        <= RESP;
                            bus_reqcyc_q <= 1'b0;
                            bus_req_q    <= '0;
                            bus_reqtag_q <= '0;
                        end
                    end
                end
                WDATA: begin
                    if (mp.bus_reqack) begin
                        state        <= IDLE;
                        bus_reqcyc_q <= 1'b0;
                        bus_req_q    <= '0;
                        bus_reqtag_q <= '0;
                        store_opn_q  <= 1'b0;
                        store_done_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_match) begin
                        if (tag_q == TAG_LOAD) begin
                            load_buffer_q <= mp.bus_resp;
                            load_done_q   <= 1'b1;
                            state         <= IDLE;
                        end else if (beat_cnt == LAST_BEAT) begin
                            beat_cnt  <= '0;
                            if_done_q <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every response beat is consumed at once; stray or mismatched tags are simply dropped.
    assign mp.bus_respack   = mp.bus_respcyc & reset;
    assign mp.if_beat_valid = resp_match && (tag_q == TAG_FETCH);
    assign mp.if_beat_data  = mp.if_beat_valid ? mp.bus_resp : '0;

    assign mp.bus_reqcyc  = bus_reqcyc_q;
    assign mp.bus_req     = bus_req_q;
    assign mp.bus_reqtag  = bus_reqtag_q;
    assign mp.store_opn   = store_opn_q;
    assign mp.store_done  = store_done_q;
    assign mp.load_done   = load_done_q;
    assign mp.if_done     = if_done_q;
    assign mp.load_buffer = load_buffer_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: load, store, fetch, tag filtering, starvation, reset.
module tb_mem_port_arbiter;
    localparam int IF_BEATS = 8;

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if bus_if();

    mem_port_arbiter #(.IF_BEATS(IF_BEATS), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .mp    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.if_req        = 1'b0;
        bus_if.if_addr       = '0;
        bus_if.data_reqFlag  = 1'b0;
        bus_if.data_reqAddr  = '0;
        bus_if.store_reqFlag = 1'b0;
        bus_if.store_reqAddr = '0;
        bus_if.store_data    = '0;
        bus_if.bus_reqack    = 1'b0;
        bus_if.bus_respcyc   = 1'b0;
        bus_if.bus_resp      = '0;
        bus_if.bus_resptag   = '0;
    endtask

    // Waits for a request, acks it and supplies the responses its tag needs.
    task automatic serve(input logic [63:0] rdata, output logic [1:0] tag, output int waited);
        waited = 0;
        while (bus_if.bus_reqcyc !== 1'b1 && waited < 10) begin
            cyc();
            waited++;
        end
        if (bus_if.bus_reqcyc !== 1'b1) begin
            chk("grant_timeout", 64'(bus_if.bus_reqcyc), 64'd1);
            tag = 2'b10;
            return;
        end
        tag = bus_if.bus_reqtag;
        bus_if.bus_reqack = 1'b1;
        cyc();
        if (tag == 2'b11) cyc();
        bus_if.bus_reqack = 1'b0;
        if (tag == 2'b01) begin
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resptag = 2'b01;
            bus_if.bus_resp    = rdata;
            cyc();
        end else if (tag == 2'b00) begin
            for (int i = 0; i < IF_BEATS; i++) begin
                bus_if.bus_respcyc = 1'b1;
                bus_if.bus_resptag = 2'b00;
                bus_if.bus_resp    = rdata + 64'(i);
                cyc();
            end
        end
        bus_if.bus_respcyc = 1'b0;
    endtask

    logic [1:0] tag;
    int         waited;
    logic [1:0] exp_tags [5];

    initial begin
        exp_tags = '{2'b11, 2'b01, 2'b11, 2'b01, 2'b00};
        reset = 1'b0;
        clear_inputs();
        repeat (3) cyc();

        // Reset state
        chk("rst_reqcyc",    64'(bus_if.bus_reqcyc), 64'd0);
        chk("rst_loadbuf",   bus_if.load_buffer, 64'd0);
        chk("rst_store_opn", 64'(bus_if.store_opn), 64'd0);
        chk("rst_dones",     64'({bus_if.load_done, bus_if.store_done, bus_if.if_done}), 64'd0);
        reset = 1'b1;
        cyc();

        // Load with a mismatched beat ahead of the real one
        bus_if.data_reqFlag = 1'b1;
        bus_if.data_reqAddr = 64'h1007;
        cyc();
        chk("ld_reqcyc", 64'(bus_if.bus_reqcyc), 64'd1);
        chk("ld_addr",   bus_if.bus_req, 64'h1000);
        chk("ld_tag",    64'(bus_if.bus_reqtag), 64'd1);
        bus_if.bus_reqack = 1'b1;
        cyc();
        bus_if.bus_reqack = 1'b0;
        chk("ld_req_drop", 64'(bus_if.bus_reqcyc), 64'd0);
        bus_if.bus_respcyc = 1'b1;
        bus_if.bus_resptag = 2'b00;
        bus_if.bus_resp    = 64'h1111;
        #1;
        chk("mis_respack", 64'(bus_if.bus_respack), 64'd1);
        chk("mis_no_beat", 64'(bus_if.if_beat_valid), 64'd0);
        cyc();
        chk("mis_loadbuf", bus_if.load_buffer, 64'd0);
        chk("mis_no_done", 64'(bus_if.load_done), 64'd0);
        bus_if.bus_resptag = 2'b01;
        bus_if.bus_resp    = 64'hDEADBEEF00112233;
        #1;
        chk("ld_respack", 64'(bus_if.bus_respack), 64'd1);
        cyc();
        bus_if.bus_respcyc = 1'b0;
        chk("ld_loadbuf", bus_if.load_buffer, 64'hDEADBEEF00112233);
        chk("ld_done",    64'(bus_if.load_done), 64'd1);
        chk("ld_masked",  64'(bus_if.bus_reqcyc), 64'd0);
        bus_if.data_reqFlag = 1'b0;
        cyc();
        chk("ld_done_pulse", 64'(bus_if.load_done), 64'd0);

        // Store: address beat then data beat
        bus_if.store_reqFlag = 1'b1;
        bus_if.store_reqAddr = 64'h2000;
        bus_if.store_data    = 64'h55AA;
        cyc();
        chk("st_addr",    bus_if.bus_req, 64'h2000);
        chk("st_tag_a",   64'(bus_if.bus_reqtag), 64'd3);
        chk("st_opn_req", 64'(bus_if.store_opn), 64'd1);
        bus_if.store_data = 64'hFFFF;
        bus_if.bus_reqack = 1'b1;
        cyc();
        chk("st_data",     bus_if.bus_req, 64'h55AA);
        chk("st_tag_d",    64'(bus_if.bus_reqtag), 64'd3);
        chk("st_opn_wd",   64'(bus_if.store_opn), 64'd1);
        chk("st_not_done", 64'(bus_if.store_done), 64'd0);
        cyc();
        bus_if.bus_reqack    = 1'b0;
        bus_if.store_reqFlag = 1'b0;
        chk("st_done",     64'(bus_if.store_done), 64'd1);
        chk("st_opn_end",  64'(bus_if.store_opn), 64'd0);
        chk("st_reqcyc",   64'(bus_if.bus_reqcyc), 64'd0);
        chk("st_loadbuf",  bus_if.load_buffer, 64'hDEADBEEF00112233);
        cyc();
        chk("st_done_pulse", 64'(bus_if.store_done), 64'd0);

        // Fetch of a full line
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 64'h3018;
        cyc();
        chk("if_addr", bus_if.bus_req, 64'h3000);
        chk("if_tag",  64'(bus_if.bus_reqtag), 64'd0);
        bus_if.bus_reqack = 1'b1;
        cyc();
        bus_if.bus_reqack = 1'b0;
        for (int i = 0; i < IF_BEATS; i++) begin
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resptag = 2'b00;
            bus_if.bus_resp    = 64'hF000 + 64'(i);
            #1;
            chk("if_beat_vld", 64'(bus_if.if_beat_valid), 64'd1);
            chk("if_beat_dat", bus_if.if_beat_data, 64'hF000 + 64'(i));
            cyc();
            if (i < IF_BEATS - 1) chk("if_early_done", 64'(bus_if.if_done), 64'd0);
        end
        bus_if.bus_respcyc = 1'b0;
        bus_if.if_req      = 1'b0;
        chk("if_done",    64'(bus_if.if_done), 64'd1);
        chk("if_cnt_zero", 64'(dut.beat_cnt), 64'd0);
        cyc();
        chk("if_done_pulse", 64'(bus_if.if_done), 64'd0);

        // Starvation: all three held; fetch wins after four data-side grants
        bus_if.if_req        = 1'b1;
        bus_if.if_addr       = 64'h4000;
        bus_if.store_reqFlag = 1'b1;
        bus_if.store_reqAddr = 64'h5000;
        bus_if.store_data    = 64'h77;
        bus_if.data_reqFlag  = 1'b1;
        bus_if.data_reqAddr  = 64'h6000;
        for (int g = 0; g < 5; g++) begin
            serve(64'hA5A5_0000_0000_0000 + 64'(g), tag, waited);
            chk("starve_tag",  64'(tag), 64'(exp_tags[g]));
            chk("starve_wait", 64'(waited), 64'd1);
        end
        chk("starve_if_done", 64'(bus_if.if_done), 64'd1);
        chk("starve_loadbuf", bus_if.load_buffer, 64'hA5A5_0000_0000_0003);
        bus_if.if_req        = 1'b0;
        bus_if.store_reqFlag = 1'b0;
        bus_if.data_reqFlag  = 1'b0;
        cyc();
        chk("starve_idle", 64'(bus_if.bus_reqcyc), 64'd0);
        chk("starve_clr",  64'(dut.fetch_starve), 64'd0);

        // Reset in the middle of a fetch line
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 64'h7040;
        cyc();
        bus_if.bus_reqack = 1'b1;
        cyc();
        bus_if.bus_reqack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resptag = 2'b00;
            bus_if.bus_resp    = 64'hB000 + 64'(i);
            cyc();
        end
        bus_if.bus_respcyc = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_reqcyc", 64'(bus_if.bus_reqcyc), 64'd0);
        chk("mrst_state",  64'(dut.state), 64'd0);
        chk("mrst_ifdone", 64'(bus_if.if_done), 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        chk("re_if_addr", bus_if.bus_req, 64'h7040);
        chk("re_if_tag",  64'(bus_if.bus_reqcyc), 64'd1);
        bus_if.bus_reqack = 1'b1;
        cyc();
        bus_if.bus_reqack = 1'b0;
        for (int i = 0; i < IF_BEATS; i++) begin
            bus_if.bus_respcyc = 1'b1;
            bus_if.bus_resptag = 2'b00;
            bus_if.bus_resp    = 64'hC000 + 64'(i);
            cyc();
            if (i < IF_BEATS - 1) chk("re_early_done", 64'(bus_if.if_done), 64'd0);
        end
        bus_if.bus_respcyc = 1'b0;
        bus_if.if_req      = 1'b0;
        chk("re_if_done", 64'(bus_if.if_done), 64'd1);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
